// File: rtl/commons.sv
// Project-wide datapath width shared by register-file blocks.
package commons;
    localparam int BITNESS = 32;
endpackage

// File: rtl/dreg_pkg.sv
// Shared types and helpers for the data-register writeback path.
package dreg_pkg;
    import commons::*;

    localparam int WORD         = BITNESS;
    localparam int NREG         = 32;
    localparam int MIRROR_SPLIT = 16;

    typedef struct packed {
        logic [4:0]      addr;
        logic [WORD-1:0] data;
        logic [WORD-1:0] mask;
    } wb_entry_t;

    // Low registers are mirrored into the upper half, so a write there dirties both.
    function automatic logic [NREG-1:0] alias_bits(input logic [4:0] addr);
        logic [NREG-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        if (addr < 5'(MIRROR_SPLIT))
            v[addr + 5'(MIRROR_SPLIT)] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; exposes per-slot valid/addr for hazard tracking.
module wb_fifo
    import dreg_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic [CW-1:0]         count,
    output logic [DEPTH-1:0]      ent_vld,
    output logic [DEPTH-1:0][4:0] ent_addr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              do_push, do_pop;

    assign do_push = push && (count < CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ent_addr[i] = mem[i].addr;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_entry;
    end

    // Push and pop never target the same slot: that needs count 0 or DEPTH, where one is blocked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (do_push) begin
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/dreg_wb.sv
// Writeback arbiter for the data register file: load beats beat ALU beats unless the ALU has
// lost STARVE arbitrations in a row; one registered masked write per cycle plus a pending map.
module dreg_wb
    import dreg_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int STARVE = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_addr,
    input  logic [WORD-1:0] alu_data,
    input  logic [WORD-1:0] alu_mask,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_addr,
    input  logic [WORD-1:0] ld_data,
    input  logic [WORD-1:0] ld_mask,
    output logic            w,
    output logic [4:0]      wa,
    output logic [WORD-1:0] wval,
    output logic [WORD-1:0] mask,
    output logic [NREG-1:0] pending,
    output logic            idle
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE + 2);

    wb_entry_t             alu_in, ld_in, alu_head, ld_head, sel;
    logic [CW-1:0]         alu_cnt, ld_cnt;
    logic [DEPTH-1:0]      alu_vld, ld_vld;
    logic [DEPTH-1:0][4:0] alu_ea, ld_ea;
    logic                  alu_ne, ld_ne, alu_win, ld_win, pop_any;
    logic [SW-1:0]         starve_cnt;
    logic [NREG-1:0]       pend_c;

    assign alu_in    = '{addr: alu_addr, data: alu_data, mask: alu_mask};
    assign ld_in     = '{addr: ld_addr, data: ld_data, mask: ld_mask};
    assign alu_ready = rst && (alu_cnt < CW'(DEPTH));
    assign ld_ready  = rst && (ld_cnt < CW'(DEPTH));

    assign alu_ne  = (alu_cnt != '0);
    assign ld_ne   = (ld_cnt != '0);
    assign alu_win = alu_ne && (!ld_ne || starve_cnt == SW'(STARVE));
    assign ld_win  = ld_ne && !alu_win;
    assign pop_any = alu_ne || ld_ne;
    assign sel     = alu_win ? alu_head : ld_head;

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst), .push(alu_valid && alu_ready), .push_entry(alu_in),
        .pop(alu_win), .head(alu_head), .count(alu_cnt), .ent_vld(alu_vld), .ent_addr(alu_ea)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
        .clk(clk), .rst(rst), .push(ld_valid && ld_ready), .push_entry(ld_in),
        .pop(ld_win), .head(ld_head), .count(ld_cnt), .ent_vld(ld_vld), .ent_addr(ld_ea)
    );

    always_comb begin
        pend_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_vld[i]) pend_c = pend_c | alias_bits(alu_ea[i]);
            if (ld_vld[i])  pend_c = pend_c | alias_bits(ld_ea[i]);
        end
        if (w) pend_c = pend_c | alias_bits(wa);
    end
    assign pending = pend_c;
    assign idle    = !alu_ne && !ld_ne && !w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            w          <= 1'b0;
            wa         <= '0;
            wval       <= '0;
            mask       <= '0;
        end else begin
            if (alu_ne && ld_win)
                starve_cnt <= (starve_cnt == SW'(STARVE)) ? starve_cnt : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
            // A zero-mask entry still burns the slot but must not strobe the register file.
            if (pop_any) begin
                w    <= (sel.mask != '0);
                wa   <= sel.addr;
                wval <= sel.data;
                mask <= sel.mask;
            end else begin
                w <= 1'b0;
            end
        end
    end
endmodule

// File: doc/dreg_wb.md
# dreg_wb

Writeback arbiter that sits directly upstream of the data register file and drives its single write port (`w`, `wa`, `wval`, `mask`). It accepts results from two producers, the ALU result path and the load-return path, over valid/ready handshakes and buffers each in a small FIFO. It issues at most one masked write per cycle. It also exports a pending-write vector so issue logic can stall on registers with writes still in flight.

## Interface
- `DEPTH`, 2: entries per source FIFO (≥1).
- `STARVE`, 3: consecutive lost arbitrations after which the ALU source is forced to win.
- Word width is `BITNESS` from `commons.sv`; "WORD" below means `BITNESS` bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `alu_valid` in 1 / `alu_ready` out 1 / `alu_addr` in 5 / `alu_data` in WORD / `alu_mask` in WORD: ALU result beat.
- `ld_valid` in 1 / `ld_ready` out 1 / `ld_addr` in 5 / `ld_data` in WORD / `ld_mask` in WORD: load-return beat.
- `w` out 1: write strobe to the register file.
- `wa` out 5: write address.
- `wval` out WORD: write data.
- `mask` out WORD: write mask (bit = 1 means take the new bit).
- `pending` out 32: per-register in-flight write flags.
- `idle` out 1: both FIFOs empty and `w` = 0.

## Operation
- **Accept.** A beat is accepted on an edge where `x_valid & x_ready`. `x_ready` = (FIFO count < DEPTH) and `rst` high. Ready depends on count only, so a full FIFO does not accept even when it pops in the same cycle.
- **Arbitrate.** Each cycle, if any FIFO is non-empty, exactly one head is popped.
  - Default priority: load > ALU.
  - ALU wins instead when its FIFO is non-empty and `starve_cnt` == STARVE.
- **Starvation counter** (`starve_cnt`, saturating at STARVE):
  - +1 when the ALU FIFO is non-empty and load wins.
  - Cleared when ALU wins or the ALU FIFO is empty.
- **Output.** The popped entry is registered into `wa`/`wval`/`mask` with `w` = 1.
  - An entry with mask == 0 is still popped and consumes the slot, but `w` = 0 that cycle.
  - When nothing is popped, `w` = 0 and `wa`/`wval`/`mask` hold their values.
- **Pending vector.** `pending` = OR over every valid FIFO entry plus the output register while `w` = 1.
  - Each contributing address `a` sets bit `a`.
  - If `a` < 16, it also sets bit `a+16` (the register file mirrors low registers into the upper half).
- **Ordering.** Writes to the same address from the same source leave in acceptance order. No ordering is guaranteed across sources.

## Timing
- **Reset** (`rst` low, asynchronous):
  - FIFOs empty; `starve_cnt` = 0.
  - `w` = 0; `wa`, `wval`, `mask` = 0.
  - `pending` = 0; `idle` = 1; both readies = 0.
  - Reset mid-operation discards all buffered beats.
  - Readies rise in the first cycle after `rst` goes high.
- **Latency:** a beat accepted on edge k with the winning FIFO otherwise empty appears with `w` = 1 after edge k+1. Throughput is 1 write/cycle.
- **Pending timing:** the `pending` bit sets after the accept edge and clears after the edge that drops `w` for that entry. It stays set if another in-flight entry covers the same register.
- **Full + simultaneous:** both sources valid every cycle with load never emptying → ALU wins one slot per every STARVE+1 cycles.

## Structure
- Package `dreg_pkg`:
  - `wb_entry_t` struct {addr[4:0], data WORD, mask WORD}.
  - Constants `NREG` = 32 and `MIRROR_SPLIT` = 16.
  - Function `alias_bits(addr)` → 32-bit one/two-hot vector.
- Sub-module `wb_fifo`: parameterized DEPTH, synchronous FIFO of `wb_entry_t` with push/pop/count and per-entry valid/addr exposed for `pending`. Instantiated twice.
- Top level holds the arbiter, starvation counter and output registers.

## Test plan
1. Reset released; ALU beat addr 5, data 0xAA, mask all-ones → `w` = 1, `wa` = 5, `wval` = 0xAA after the next edge; `pending[5]` and `pending[21]` set and then clear.
2. Load and ALU valid in the same cycle (addr 3 and addr 20) → load write to 3 first, then ALU write to 20; `pending[20]` set alone (addr 20 ≥ 16, so no mirror).
3. Load streams continuously with the ALU FIFO full, STARVE = 3 → ALU wins every 4th cycle; the ALU source is not starved indefinitely.
4. Feed DEPTH+1 ALU beats back-to-back with no load traffic → `alu_ready` drops only while count == DEPTH; all beats are written in order and none is lost.
5. Beat with mask 0 → `w` stays 0 in its slot, `pending` clears, and the next beat follows with no bubble added.
6. `rst` asserted with both FIFOs full → `w`, `pending` and readies go 0 asynchronously; after release, `idle` = 1 and no stale write appears.
